// File: rtl/regmap_arb_pkg.sv
// Shared types and defaults for the two-master register-map bus arbiter.
package regmap_arb_pkg;

    localparam int DEFAULT_AW = 3;
    localparam int DEFAULT_DW = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } arb_state_t;

    // Index of a bus master: 0 or 1.
    typedef logic master_idx_t;

endpackage

// File: rtl/regmap_bus_arbiter_if.sv
// Register-map side of the arbiter: strobes, address and data toward the packed control registers.
interface regmap_bus_arbiter_if
    import regmap_arb_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW
);
    logic          WRITE;
    logic          READ;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] WRITE_DATA;
    logic [DW-1:0] READ_DATA;

    modport master (
        output WRITE,
        output READ,
        output ADDR,
        output WRITE_DATA,
        input  READ_DATA
    );

    modport slave (
        input  WRITE,
        input  READ,
        input  ADDR,
        input  WRITE_DATA,
        output READ_DATA
    );
endinterface

// File: rtl/regmap_arb_pick.sv
// Winner selection between two masters. REGMAP_ARB_RR_EN selects round-robin
// (with a last-granted pointer); otherwise master 0 has fixed priority.
module regmap_arb_pick
    import regmap_arb_pkg::*;
(
`ifdef REGMAP_ARB_RR_EN
    input  logic        CLK,
    input  logic        RST,
    input  logic        grant,
`endif
    input  logic        req0,
    input  logic        req1,
    output master_idx_t winner
);

`ifdef REGMAP_ARB_RR_EN
    // Remembers who was granted last; resets to master 1 so master 0 takes the first tie.
    master_idx_t last_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_reg <= 1'b1;
        end else if (grant) begin
            last_reg <= winner;
        end
    end

    always_comb begin
        if (req0 && req1) begin
            winner = ~last_reg;
        end else begin
            winner = ~req0;
        end
    end
`else
    assign winner = ~req0;
`endif

endmodule

// File: rtl/regmap_bus_arbiter.sv
// Two-master arbiter/sequencer for the register-map bus: one strobe per granted
// request, read-data capture, one-cycle ACK. REGMAP_ARB_RR_EN enables round-robin ties.
module regmap_bus_arbiter
    import regmap_arb_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA0,
    input  logic [DW-1:0] WDATA1,
    output logic          ACK0,
    output logic          ACK1,
    output logic [DW-1:0] RDATA,
    regmap_bus_arbiter_if.master rmap
);

    arb_state_t    state_reg;
    arb_state_t    state_next;
    master_idx_t   win_reg;
    master_idx_t   winner;
    logic          we_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic [DW-1:0] rdata_reg;
    logic          grant;

    assign grant = (state_reg == IDLE) && (REQ0 || REQ1);

    regmap_arb_pick u_pick (
`ifdef REGMAP_ARB_RR_EN
        .CLK    (CLK),
        .RST    (RST),
        .grant  (grant),
`endif
        .req0   (REQ0),
        .req1   (REQ1),
        .winner (winner)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            win_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                win_reg   <= winner;
                we_reg    <= winner ? WE1 : WE0;
                addr_reg  <= winner ? ADDR1 : ADDR0;
                wdata_reg <= winner ? WDATA1 : WDATA0;
            end
            // READ_DATA answers the strobe one cycle late, which is exactly the CAPTURE cycle.
            if (state_reg == CAPTURE) begin
                rdata_reg <= rmap.READ_DATA;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        rmap.WRITE      = 1'b0;
        rmap.READ       = 1'b0;
        rmap.ADDR       = '0;
        rmap.WRITE_DATA = '0;
        ACK0            = 1'b0;
        ACK1            = 1'b0;
        case (state_reg)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                rmap.WRITE      = we_reg;
                rmap.READ       = ~we_reg;
                rmap.ADDR       = addr_reg;
                rmap.WRITE_DATA = wdata_reg;
                state_next      = we_reg ? DONE : CAPTURE;
            end
            CAPTURE: begin
                state_next = DONE;
            end
            DONE: begin
                ACK0       = ~win_reg;
                ACK1       = win_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign RDATA = rdata_reg;

endmodule

// File: tb/tb_regmap_bus_arbiter.sv
// Directed bench for regmap_bus_arbiter: expected transactions are queued when a request
// is driven and retired when the matching ACK appears; strobes are checked against the queue head.
module tb_regmap_bus_arbiter;

    logic       CLK;
    logic       RST;
    logic       REQ0;
    logic       REQ1;
    logic       WE0;
    logic       WE1;
    logic [2:0] ADDR0;
    logic [2:0] ADDR1;
    logic [3:0] WDATA0;
    logic [3:0] WDATA1;
    logic       ACK0;
    logic       ACK1;
    logic [3:0] RDATA;

    regmap_bus_arbiter_if #(.AW(3), .DW(4)) bus ();

    regmap_bus_arbiter #(.AW(3), .DW(4)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ0   (REQ0),
        .REQ1   (REQ1),
        .WE0    (WE0),
        .WE1    (WE1),
        .ADDR0  (ADDR0),
        .ADDR1  (ADDR1),
        .WDATA0 (WDATA0),
        .WDATA1 (WDATA1),
        .ACK0   (ACK0),
        .ACK1   (ACK1),
        .RDATA  (RDATA),
        .rmap   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register-map responder: data is valid only in the cycle after READ, filler otherwise.
    always @(posedge CLK) begin
        bus.READ_DATA <= bus.READ ? ({1'b0, bus.ADDR} ^ 4'h4) : 4'hE;
    end

    typedef struct {
        int         m;
        bit         we;
        logic [2:0] addr;
        logic [3:0] wdata;
        logic [3:0] rdata;
        int         strobe_cyc;
        int         ack_cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    bit         hold0    = 1'b0;
    logic [3:0] last_rd  = 4'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge CLK);
        #1;
        cyc++;
        chk("strobe_exclusive", {31'b0, bus.WRITE & bus.READ}, 32'd0);
        if (bus.WRITE || bus.READ) begin
            chk("strobe_expected", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb[0];
                chk("strobe_cycle", cyc, e.strobe_cyc);
                chk("strobe_write", {31'b0, bus.WRITE}, {31'b0, e.we});
                chk("strobe_addr", {29'b0, bus.ADDR}, {29'b0, e.addr});
                chk("strobe_wdata", {28'b0, bus.WRITE_DATA}, {28'b0, e.wdata});
            end
        end else begin
            chk("addr_idle_zero", {29'b0, bus.ADDR}, 32'd0);
            chk("wdata_idle_zero", {28'b0, bus.WRITE_DATA}, 32'd0);
        end
        if (ACK0 || ACK1) begin
            chk("ack_expected", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ack_master", {30'b0, ACK1, ACK0}, (e.m != 0) ? 32'd2 : 32'd1);
                chk("ack_cycle", cyc, e.ack_cyc);
                chk("ack_rdata", {28'b0, RDATA}, {28'b0, e.rdata});
                $display("txn m%0d %s addr=%0d wdata=%h rdata=%h ack@%0d",
                         e.m, e.we ? "WR" : "RD", e.addr, e.wdata, RDATA, cyc);
            end
            if (ACK0 && !hold0) REQ0 = 1'b0;
            if (ACK1) REQ1 = 1'b0;
        end
    endtask

    task automatic drive(input int m, input bit we, input logic [2:0] a, input logic [3:0] d);
        if (m == 0) begin
            REQ0 = 1'b1; WE0 = we; ADDR0 = a; WDATA0 = d;
        end else begin
            REQ1 = 1'b1; WE1 = we; ADDR1 = a; WDATA1 = d;
        end
    endtask

    task automatic push(input int m, input bit we, input logic [2:0] a, input logic [3:0] d,
                        input logic [3:0] rd, input int sc, input int ac);
        exp_t e;
        e.m = m; e.we = we; e.addr = a; e.wdata = d; e.rdata = rd;
        e.strobe_cyc = sc; e.ack_cyc = ac;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_timeout", sb.size(), 32'd0);
        tick();
    endtask

    // One request from a lone master; a read updates the value RDATA must hold afterwards.
    task automatic single(input int m, input bit we, input logic [2:0] a, input logic [3:0] d,
                          input logic [3:0] rd);
        if (!we) last_rd = rd;
        drive(m, we, a, d);
        push(m, we, a, d, last_rd, cyc + 1, cyc + (we ? 2 : 3));
        wait_done(20);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_write", {31'b0, bus.WRITE}, 32'd0);
        chk("rst_read", {31'b0, bus.READ}, 32'd0);
        chk("rst_addr", {29'b0, bus.ADDR}, 32'd0);
        chk("rst_wdata", {28'b0, bus.WRITE_DATA}, 32'd0);
        chk("rst_ack0", {31'b0, ACK0}, 32'd0);
        chk("rst_ack1", {31'b0, ACK1}, 32'd0);
        chk("rst_rdata", {28'b0, RDATA}, 32'd0);
    endtask

    initial begin
        int c;
        RST = 1'b1;
        REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
        tick();
        tick();
        chk_reset_outputs();
        RST = 1'b0;
        tick();

        // Lone write from master 0, lone read from master 1 (WRITE_DATA still driven on a read).
        single(0, 1'b1, 3'd1, 4'hA, 4'h0);
        single(1, 1'b0, 3'd1, 4'h6, 4'h5);

        // Simultaneous writes from reset pointer: master 0 first, master 1 three cycles later.
        c = cyc;
        drive(0, 1'b1, 3'd2, 4'h3);
        drive(1, 1'b1, 3'd3, 4'h9);
        push(0, 1'b1, 3'd2, 4'h3, last_rd, c + 1, c + 2);
        push(1, 1'b1, 3'd3, 4'h9, last_rd, c + 4, c + 5);
        wait_done(20);

        // Second tie after master 1 was served last: master 0 wins either way.
        c = cyc;
        drive(0, 1'b1, 3'd5, 4'h1);
        drive(1, 1'b1, 3'd6, 4'h2);
        push(0, 1'b1, 3'd5, 4'h1, last_rd, c + 1, c + 2);
        push(1, 1'b1, 3'd6, 4'h2, last_rd, c + 4, c + 5);
        wait_done(20);

`ifdef REGMAP_ARB_RR_EN
        // Master 0 granted last, so the next tie goes to master 1.
        single(0, 1'b1, 3'd5, 4'h1, 4'h0);
        c = cyc;
        drive(0, 1'b1, 3'd6, 4'h7);
        drive(1, 1'b1, 3'd0, 4'h8);
        push(1, 1'b1, 3'd0, 4'h8, last_rd, c + 1, c + 2);
        push(0, 1'b1, 3'd6, 4'h7, last_rd, c + 4, c + 5);
        wait_done(20);
`else
        // Fixed priority: REQ0 held high starves master 1 until it drops.
        c = cyc;
        hold0 = 1'b1;
        drive(0, 1'b1, 3'd6, 4'h7);
        drive(1, 1'b1, 3'd0, 4'h8);
        for (int i = 0; i < 3; i++) begin
            push(0, 1'b1, 3'd6, 4'h7, last_rd, c + 1 + 3 * i, c + 2 + 3 * i);
        end
        while (cyc < c + 8) tick();
        hold0 = 1'b0;
        REQ0 = 1'b0;
        push(1, 1'b1, 3'd0, 4'h8, last_rd, c + 10, c + 11);
        wait_done(20);
`endif

        // A write leaves the previously read value on RDATA.
        single(1, 1'b0, 3'd7, 4'h0, 4'h3);
        single(0, 1'b1, 3'd4, 4'hC, 4'h0);

        // Reset during CAPTURE drops the read: no ACK, everything back to zero.
        c = cyc;
        drive(0, 1'b0, 3'd1, 4'h0);
        push(0, 1'b0, 3'd1, 4'h0, 4'h5, c + 1, c + 3);
        tick();
        tick();
        sb.delete();
        RST = 1'b1;
        REQ0 = 1'b0;
        tick();
        chk_reset_outputs();
        RST = 1'b0;
        last_rd = 4'h0;
        repeat (3) tick();
        single(0, 1'b0, 3'd2, 4'h0, 4'h6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
